pc_sequencer: RTL and testbench

- Program-counter controller for the MIPS datapath.
- Owns the PC register and decides the next fetch address every cycle.
- Chooses between sequential fetch, conditional branch, J-format jump and jump-register.
- Also handles pipeline stall, halt/resume, and a misaligned jump-register trap to a fixed exception vector.
- Sits between the decode/control unit and instruction memory; computes the J-format jump target internally from PC+4 and the 26-bit field.

---
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter controller for the MIPS datapath: owns the PC register and
// selects sequential, branch, jump, jump-register or trap fetch addresses.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_field,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic [1:0]  seq_state,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HALT  = 2'b10
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx;
  logic        redirect_nx;
  logic        err_nx;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  // The shift drops branch_offset[31:30]; the sum wraps modulo 2^32.
  assign branch_target = pc_plus4 + (branch_offset << 2);
  assign jump_target   = {pc_plus4[31:28], jump_field, 2'b00};
  assign seq_state     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      redirect     <= redirect_nx;
      misalign_err <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    redirect_nx = 1'b0;
    err_nx      = misalign_err;
    unique case (state)
      RUN: begin
        if (stall) begin
          state_nx = STALL;
        end else begin
          if (jump_reg && (jr_target[1:0] != 2'b00)) begin
            pc_nx       = EXC_VECTOR;
            err_nx      = 1'b1;
            redirect_nx = 1'b1;
          end else if (jump_reg) begin
            pc_nx       = jr_target;
            redirect_nx = 1'b1;
          end else if (jump) begin
            pc_nx       = jump_target;
            redirect_nx = 1'b1;
          end else if (branch_taken) begin
            pc_nx       = branch_target;
            redirect_nx = 1'b1;
          end else begin
            pc_nx = pc_plus4;
          end
          if (halt) state_nx = HALT;
        end
      end
      // Leaving STALL spends one edge re-entering RUN with the held pc.
      STALL: begin
        if (!stall) state_nx = RUN;
      end
      HALT: begin
        if (resume) state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues the expected post-edge
// state, a monitor pops and compares one entry after every rising edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_field;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [1:0]  seq_state;
  logic        misalign_err;

  typedef struct packed {
    logic [31:0] pc;
    logic        red;
    logic [1:0]  st;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic        mon_ok;
  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  pc_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0080)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_field   (jump_field),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .halt         (halt),
    .resume       (resume),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect),
    .seq_state    (seq_state),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e  = q.pop_front();
      mon_ok = 1'b1;
      nvec++;
      if (pc !== mon_e.pc) begin
        $display("FAIL vec%0d pc: got %h want %h", nvec, pc, mon_e.pc);
        mon_ok = 1'b0;
      end
      if (pc_plus4 !== mon_e.pc + 32'd4) begin
        $display("FAIL vec%0d pc_plus4: got %h want %h", nvec, pc_plus4, mon_e.pc + 32'd4);
        mon_ok = 1'b0;
      end
      if (redirect !== mon_e.red) begin
        $display("FAIL vec%0d redirect: got %b want %b", nvec, redirect, mon_e.red);
        mon_ok = 1'b0;
      end
      if (seq_state !== mon_e.st) begin
        $display("FAIL vec%0d seq_state: got %b want %b", nvec, seq_state, mon_e.st);
        mon_ok = 1'b0;
      end
      if (misalign_err !== mon_e.err) begin
        $display("FAIL vec%0d misalign_err: got %b want %b", nvec, misalign_err, mon_e.err);
        mon_ok = 1'b0;
      end
      if (!mon_ok) nfail++;
    end
  end

  task automatic clr();
    stall = 0; branch_taken = 0; branch_offset = '0; jump = 0; jump_field = '0;
    jump_reg = 0; jr_target = '0; halt = 0; resume = 0;
  endtask

  task automatic cyc(input logic [31:0] p, input logic r, input logic [1:0] s, input logic e);
    q.push_back({p, r, s, e});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk_now({tag, "_pc"}, pc, 32'h0);
    chk_now({tag, "_redirect"}, {31'b0, redirect}, 32'h0);
    chk_now({tag, "_state"}, {30'b0, seq_state}, 32'h0);
    chk_now({tag, "_err"}, {31'b0, misalign_err}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset("reset");

    // sequential fetch
    cyc(32'h4, 0, 2'b00, 0);
    cyc(32'h8, 0, 2'b00, 0);
    cyc(32'hC, 0, 2'b00, 0);

    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1 chk_reset("midreset");
    @(negedge clk);
    reset = 1'b0;

    // jump targets
    clr(); jump = 1; jump_field = 26'd10;         cyc(32'h28, 1, 2'b00, 0);
    clr();                                        cyc(32'h2C, 0, 2'b00, 0);
    clr(); jump_reg = 1; jr_target = 32'hC;       cyc(32'hC, 1, 2'b00, 0);
    clr(); jump = 1; jump_field = 26'd50;         cyc(32'hC8, 1, 2'b00, 0);
    clr(); jump_reg = 1; jr_target = 32'h1C;      cyc(32'h1C, 1, 2'b00, 0);
    clr(); jump = 1; jump_field = 26'd99;         cyc(32'h18C, 1, 2'b00, 0);

    // priority, branch arithmetic, redirect to pc_plus4
    clr(); jump_reg = 1; jr_target = 32'h100; jump = 1; jump_field = 26'd10;
    branch_taken = 1; branch_offset = 32'd5;      cyc(32'h100, 1, 2'b00, 0);
    clr(); jump_reg = 1; jr_target = 32'h40;      cyc(32'h40, 1, 2'b00, 0);
    clr(); branch_taken = 1; branch_offset = 32'hFFFF_FFFE; cyc(32'h3C, 1, 2'b00, 0);
    clr(); branch_taken = 1; branch_offset = 32'h4000_0001; cyc(32'h44, 1, 2'b00, 0);
    clr(); branch_taken = 1; branch_offset = 32'h0;         cyc(32'h48, 1, 2'b00, 0);
    clr(); jump = 1; jump_field = 26'd200; branch_taken = 1; branch_offset = 32'd1;
                                                  cyc(32'h320, 1, 2'b00, 0);

    // misaligned JR traps, sticky flag, second trap
    clr(); jump_reg = 1; jr_target = 32'h102;     cyc(32'h80, 1, 2'b00, 1);
    clr();
    cyc(32'h84, 0, 2'b00, 1);
    cyc(32'h88, 0, 2'b00, 1);
    cyc(32'h8C, 0, 2'b00, 1);
    cyc(32'h90, 0, 2'b00, 1);
    cyc(32'h94, 0, 2'b00, 1);
    clr(); jump_reg = 1; jr_target = 32'h3;       cyc(32'h80, 1, 2'b00, 1);

    // stall: redirects ignored, halt ignored in STALL, release edge holds pc
    clr(); jump_reg = 1; jr_target = 32'h10;      cyc(32'h10, 1, 2'b00, 1);
    clr(); stall = 1; jump = 1; jump_field = 26'd10; cyc(32'h10, 0, 2'b01, 1);
    halt = 1;                                     cyc(32'h10, 0, 2'b01, 1);
    halt = 0;                                     cyc(32'h10, 0, 2'b01, 1);
    clr(); jump = 1; jump_field = 26'd10;         cyc(32'h10, 0, 2'b00, 1);
    clr();                                        cyc(32'h14, 0, 2'b00, 1);

    // halt, frozen pc, resume wins over halt
    clr(); jump_reg = 1; jr_target = 32'h20;      cyc(32'h20, 1, 2'b00, 1);
    clr(); halt = 1;                              cyc(32'h24, 0, 2'b10, 1);
    clr(); stall = 1;                             cyc(32'h24, 0, 2'b10, 1);
    clr(); jump = 1; jump_field = 26'd7;          cyc(32'h24, 0, 2'b10, 1);
    clr(); jump_reg = 1; jr_target = 32'h3;       cyc(32'h24, 0, 2'b10, 1);
    clr(); branch_taken = 1; branch_offset = 32'd4; cyc(32'h24, 0, 2'b10, 1);
    clr(); resume = 1; halt = 1;                  cyc(32'h24, 0, 2'b00, 1);
    clr();                                        cyc(32'h28, 0, 2'b00, 1);

    // halt together with a jump: redirect applied, then frozen
    clr(); halt = 1; jump = 1; jump_field = 26'd10; cyc(32'h28, 1, 2'b10, 1);
    clr();                                        cyc(32'h28, 0, 2'b10, 1);
    clr(); resume = 1;                            cyc(32'h28, 0, 2'b00, 1);

    // wrap-around and jump upper nibble from pc_plus4
    clr(); jump_reg = 1; jr_target = 32'hFFFF_FFFC; cyc(32'hFFFF_FFFC, 1, 2'b00, 1);
    clr();                                        cyc(32'h0, 0, 2'b00, 1);
    clr(); jump_reg = 1; jr_target = 32'hF000_0000; cyc(32'hF000_0000, 1, 2'b00, 1);
    clr(); jump = 1; jump_field = 26'h3FF_FFFF;   cyc(32'hFFFF_FFFC, 1, 2'b00, 1);

    // asynchronous reset while halted clears the sticky flag
    clr(); jump_reg = 1; jr_target = 32'h200;     cyc(32'h200, 1, 2'b00, 1);
    clr(); halt = 1;                              cyc(32'h204, 0, 2'b10, 1);
    clr();
    #2 reset = 1'b1;
    #1 chk_reset("haltreset");
    @(negedge clk);
    reset = 1'b0;
    cyc(32'h4, 0, 2'b00, 0);

    repeat (2) @(negedge clk);
    chk_now("queue_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
